// File: rtl/approx_arith_pkg.sv
// Shared types and constants for the approximate arithmetic datapath.
// Holds the divider FSM state encoding, default widths and divide-by-zero constants.
package approx_arith_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam int DW_DEF = 8;
    localparam int QW_DEF = 16;
    localparam int CNT_W  = $clog2(2*DW_DEF+1);

    localparam logic [QW_DEF-1:0] QZERO_VAL = '1;

endpackage

// File: rtl/approx_div_step.sv
// One combinational restoring-division iteration: shift in the next dividend
// bit, compare with the divisor, and subtract when it fits.
module div_step #(
    parameter int DW = 8
) (
    input  logic [DW-1:0] pr_i,
    input  logic          bit_i,
    input  logic [DW-1:0] dvs_i,
    output logic [DW-1:0] pr_o,
    output logic          q_o
);

    logic [DW:0] wide;

    assign wide = {pr_i, bit_i};

    // The true difference is always below the divisor, so DW bits hold it exactly.
    always_comb begin
        q_o  = 1'b0;
        pr_o = wide[DW-1:0];
        if (wide >= {1'b0, dvs_i}) begin
            q_o  = 1'b1;
            pr_o = wide[DW-1:0] - dvs_i;
        end
    end

endmodule

// File: rtl/approx_div.sv
// Sequential restoring divider, one quotient bit per clock, valid/ready on both sides.
// Define APPROX_DIV_EN to skip the low APPROX_K quotient bits (midpoint fill, remainder 0).
module approx_div
    import approx_arith_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int APPROX_K = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2*DW-1:0] dividend,
    input  logic [DW-1:0]   divisor,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*DW-1:0] quotient,
    output logic [DW-1:0]   remainder,
    output logic            div_zero
);

    localparam int QW = 2*DW;
    localparam int CW = (DW == DW_DEF) ? CNT_W : $clog2(QW+1);
    localparam logic [QW-1:0] QZERO = (QW == QW_DEF) ? QW'(QZERO_VAL) : '1;

`ifdef APPROX_DIV_EN
    localparam int STEPS = QW - APPROX_K;
    localparam logic [QW-1:0] MID = QW'(1) << (APPROX_K - 1);
`else
    localparam int STEPS = QW;
`endif

    if (APPROX_K < 1 || APPROX_K > QW-1) begin : g_k_range
        $error("approx_div: APPROX_K out of range 1..2*DW-1");
    end

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [DW-1:0]   pr_q;
    logic [QW-1:0]   dvd_q;
    logic [DW-1:0]   dvs_q;
    logic [QW-2:0]   qw_q;
    logic [QW-1:0]   quot_q;
    logic [DW-1:0]   rem_q;
    logic            dz_q;
    logic            ov_q;
    logic            ir_q;

    logic [DW-1:0]   pr_d;
    logic            qbit_d;
    logic [QW-1:0]   q_full_d;
    logic [QW-1:0]   q_fin_d;
    logic [DW-1:0]   rem_fin_d;

    div_step #(.DW(DW)) u_step (
        .pr_i  (pr_q),
        .bit_i (dvd_q[QW-1]),
        .dvs_i (dvs_q),
        .pr_o  (pr_d),
        .q_o   (qbit_d)
    );

    assign q_full_d = {qw_q, qbit_d};

    always_comb begin
`ifdef APPROX_DIV_EN
        q_fin_d   = (q_full_d << APPROX_K) | MID;
        rem_fin_d = '0;
`else
        q_fin_d   = q_full_d;
        rem_fin_d = pr_d;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pr_q    <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            qw_q    <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
            ov_q    <= 1'b0;
            ir_q    <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && ir_q) begin
                        dvd_q <= dividend;
                        dvs_q <= divisor;
                        ir_q  <= 1'b0;
                        if (divisor == '0) begin
                            state_q <= DONE;
                            quot_q  <= QZERO;
                            rem_q   <= dividend[DW-1:0];
                            dz_q    <= 1'b1;
                            ov_q    <= 1'b1;
                        end else begin
                            state_q <= CALC;
                            cnt_q   <= '0;
                            pr_q    <= '0;
                            qw_q    <= '0;
                        end
                    end
                end
                CALC: begin
                    pr_q  <= pr_d;
                    qw_q  <= q_full_d[QW-2:0];
                    dvd_q <= {dvd_q[QW-2:0], 1'b0};
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(STEPS-1)) begin
                        state_q <= DONE;
                        quot_q  <= q_fin_d;
                        rem_q   <= rem_fin_d;
                        dz_q    <= 1'b0;
                        ov_q    <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                        ov_q    <= 1'b0;
                        ir_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ov_q    <= 1'b0;
                    ir_q    <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = ir_q;
    assign out_valid = ov_q;
    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign div_zero  = dz_q;

endmodule

// File: tb/tb_approx_div.sv
// Directed self-checking bench for approx_div; expected values follow APPROX_DIV_EN.
module tb_approx_div;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_zero;

    int checks;
    int failures;

`ifdef APPROX_DIV_EN
    localparam int LAT       = 12;
    localparam int Q_1000_7  = 136;
    localparam int R_1000_7  = 0;
    localparam int Q_65535_1 = 65528;
    localparam int Q_5_200   = 8;
    localparam int R_5_200   = 0;
    localparam int Q_50000_3 = 16664;
    localparam int R_50000_3 = 0;
    localparam int Q_0_9     = 8;
`else
    localparam int LAT       = 16;
    localparam int Q_1000_7  = 142;
    localparam int R_1000_7  = 6;
    localparam int Q_65535_1 = 65535;
    localparam int Q_5_200   = 0;
    localparam int R_5_200   = 5;
    localparam int Q_50000_3 = 16666;
    localparam int R_50000_3 = 2;
    localparam int Q_0_9     = 0;
`endif

    approx_div #(.DW(8), .APPROX_K(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [15:0] dvd, input logic [7:0] dvs);
        check("ready_before_accept", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        dividend = dvd;
        divisor  = dvs;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = 16'hDEAD;
        divisor  = 8'h5A;
    endtask

    // Edges after the acceptance edge until out_valid; also notes whether in_ready stayed low.
    task automatic wait_out(output int n, output logic busy_ok);
        n = 0;
        busy_ok = 1'b1;
        while (!out_valid && n < 40) begin
            if (in_ready !== 1'b0) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        if (in_ready !== 1'b0) busy_ok = 1'b0;
    endtask

    task automatic handshake();
        @(posedge clk);
        #1;
        check("valid_drop_after_hs", {31'd0, out_valid}, 32'd0);
        check("ready_after_hs", {31'd0, in_ready}, 32'd1);
    endtask

    int          n;
    logic        busy_ok;
    logic        stable_ok;
    logic [15:0] q_hold;
    logic [7:0]  r_hold;

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        #12;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_quotient", {16'd0, quotient}, 32'd0);
        check("rst_remainder", {24'd0, remainder}, 32'd0);
        check("rst_div_zero", {31'd0, div_zero}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1000 / 7
        out_ready = 1'b1;
        start(16'd1000, 8'd7);
        wait_out(n, busy_ok);
        check("t1_latency", n, LAT);
        check("t1_busy_not_ready", {31'd0, busy_ok}, 32'd1);
        check("t1_quotient", {16'd0, quotient}, Q_1000_7);
        check("t1_remainder", {24'd0, remainder}, R_1000_7);
        check("t1_div_zero", {31'd0, div_zero}, 32'd0);
        handshake();

        // 65535 / 1, then 5 / 200 right after the handshake
        start(16'd65535, 8'd1);
        wait_out(n, busy_ok);
        check("t2_latency", n, LAT);
        check("t2_quotient", {16'd0, quotient}, Q_65535_1);
        check("t2_remainder", {24'd0, remainder}, 32'd0);
        handshake();
        start(16'd5, 8'd200);
        check("t2b_accepted", {31'd0, in_ready}, 32'd0);
        wait_out(n, busy_ok);
        check("t2b_latency", n, LAT);
        check("t2b_quotient", {16'd0, quotient}, Q_5_200);
        check("t2b_remainder", {24'd0, remainder}, R_5_200);
        handshake();

        // 100 / 0
        start(16'd100, 8'd0);
        wait_out(n, busy_ok);
        check("t3_latency", n, 0);
        check("t3_quotient", {16'd0, quotient}, 32'h0000FFFF);
        check("t3_remainder", {24'd0, remainder}, 32'd100);
        check("t3_div_zero", {31'd0, div_zero}, 32'd1);
        handshake();

        // Backpressure on 1000 / 7
        out_ready = 1'b0;
        start(16'd1000, 8'd7);
        wait_out(n, busy_ok);
        check("t4_latency", n, LAT);
        q_hold = quotient;
        r_hold = remainder;
        stable_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (quotient !== q_hold || remainder !== r_hold || out_valid !== 1'b1 || in_ready !== 1'b0)
                stable_ok = 1'b0;
        end
        check("t4_stable_under_bp", {31'd0, stable_ok}, 32'd1);
        check("t4_quotient", {16'd0, q_hold}, Q_1000_7);
        check("t4_remainder", {24'd0, r_hold}, R_1000_7);
        out_ready = 1'b1;
        handshake();
        check("t4_quotient_held_idle", {16'd0, quotient}, Q_1000_7);

        // Reset part-way through 50000 / 3
        start(16'd50000, 8'd3);
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("t5_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("t5_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("t5_rst_quotient", {16'd0, quotient}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        start(16'd50000, 8'd3);
        wait_out(n, busy_ok);
        check("t5_latency", n, LAT);
        check("t5_quotient", {16'd0, quotient}, Q_50000_3);
        check("t5_remainder", {24'd0, remainder}, R_50000_3);
        handshake();

        // Zero dividend
        start(16'd0, 8'd9);
        wait_out(n, busy_ok);
        check("t6_quotient", {16'd0, quotient}, Q_0_9);
        check("t6_remainder", {24'd0, remainder}, 32'd0);
        handshake();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
